// File: rtl/cp0_regs_pkg.sv
// CP0 shared definitions: operation codes, register numbers,
// Status/Cause field positions. Also consumed by the CP0 forwarding unit.
package cp0_regs_pkg;

  localparam logic [2:0] OP_NONE    = 3'b000;
  localparam logic [2:0] OP_MFC0    = 3'b001;
  localparam logic [2:0] OP_MTC0    = 3'b010;
  localparam logic [2:0] OP_SYSCALL = 3'b011;
  localparam logic [2:0] OP_ERET    = 3'b100;

  localparam logic [4:0] CS_COUNT  = 5'd9;
  localparam logic [4:0] CS_STATUS = 5'd12;
  localparam logic [4:0] CS_CAUSE  = 5'd13;
  localparam logic [4:0] CS_EPC    = 5'd14;

  localparam logic [2:0] SEL_0 = 3'd0;

  localparam int         EXL_BIT      = 1;
  localparam logic [4:0] EXC_SYSCALL  = 5'd8;

endpackage

// File: rtl/cp0_regs.sv
// CP0 register file: Count/Status/Cause/EPC, SYSCALL/ERET handling
// and a registered one-cycle PC redirect request.
module cp0_regs
  import cp0_regs_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0004,
  parameter logic [31:0] STATUS_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cp0Op,
  input  logic [4:0]  cs,
  input  logic [2:0]  sel,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic [31:0] epc,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  logic [31:0] count_q, count_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        rv_q, rv_d;
  logic [31:0] rpc_q, rpc_d;

  logic is_mtc0;
  logic is_sys;
  logic is_eret;

  assign is_mtc0 = (cp0Op == OP_MTC0) && (sel == SEL_0);
  assign is_sys  = (cp0Op == OP_SYSCALL);
  assign is_eret = (cp0Op == OP_ERET);

  always_comb begin
    rdata = '0;
    if (cp0Op == OP_MFC0 && sel == SEL_0) begin
      case (cs)
        CS_COUNT:  rdata = count_q;
        CS_STATUS: rdata = status_q;
        CS_CAUSE:  rdata = cause_q;
        CS_EPC:    rdata = epc_q;
        default:   rdata = '0;
      endcase
    end
  end

  always_comb begin
    count_d  = count_q + 32'd1;
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    rv_d     = 1'b0;
    rpc_d    = rpc_q;
    unique case (1'b1)
      is_mtc0: begin
        case (cs)
          CS_COUNT:  count_d  = wdata;
          CS_STATUS: status_d = wdata;
          CS_CAUSE:  cause_d  = wdata;
          CS_EPC:    epc_d    = wdata;
          default: ;
        endcase
      end
      is_sys: begin
        // A nested SYSCALL keeps the original return address.
        if (!status_q[EXL_BIT]) begin
          epc_d             = pc;
          status_d[EXL_BIT] = 1'b1;
        end
        cause_d[6:2] = EXC_SYSCALL;
        rv_d         = 1'b1;
        rpc_d        = EXC_VECTOR;
      end
      is_eret: begin
        status_d[EXL_BIT] = 1'b0;
        rv_d              = 1'b1;
        rpc_d             = epc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      status_q <= STATUS_RESET;
      cause_q  <= '0;
      epc_q    <= '0;
      rv_q     <= 1'b0;
      rpc_q    <= '0;
    end else begin
      count_q  <= count_d;
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      rv_q     <= rv_d;
      rpc_q    <= rpc_d;
    end
  end

  assign epc            = epc_q;
  assign status         = status_q;
  assign cause          = cause_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_cp0_regs.sv
// Randomized and directed bench for cp0_regs against a
// behavioural CP0 model.
module tb_cp0_regs;

  localparam logic [31:0] EXC  = 32'h8000_0180;
  localparam logic [31:0] SRST = 32'h0000_FF00;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cp0Op;
  logic [4:0]  cs;
  logic [2:0]  sel;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic [31:0] epc;
  logic [31:0] status;
  logic [31:0] cause;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_count, m_status, m_cause, m_epc, m_rpc;
  logic        m_rv;

  cp0_regs #(.EXC_VECTOR(EXC), .STATUS_RESET(SRST)) dut (
    .clk(clk), .rst(rst), .cp0Op(cp0Op), .cs(cs), .sel(sel),
    .wdata(wdata), .pc(pc), .rdata(rdata), .epc(epc),
    .status(status), .cause(cause),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] op,
                                         input logic [4:0] c,
                                         input logic [2:0] s);
    if (op != 3'd1 || s != 3'd0) return 32'd0;
    if (c == 5'd9)  return m_count;
    if (c == 5'd12) return m_status;
    if (c == 5'd13) return m_cause;
    if (c == 5'd14) return m_epc;
    return 32'd0;
  endfunction

  task automatic model_edge(input logic [2:0] op, input logic [4:0] c,
                            input logic [2:0] s, input logic [31:0] wd,
                            input logic [31:0] p, input logic r);
    logic [31:0] old_epc;
    logic        old_exl;
    if (r) begin
      m_count = 0; m_status = SRST; m_cause = 0;
      m_epc = 0; m_rv = 0; m_rpc = 0;
      return;
    end
    old_epc = m_epc;
    old_exl = m_status[1];
    m_rv    = 0;
    m_count = m_count + 1;
    if (op == 3'd2 && s == 3'd0) begin
      if (c == 5'd9)  m_count  = wd;
      if (c == 5'd12) m_status = wd;
      if (c == 5'd13) m_cause  = wd;
      if (c == 5'd14) m_epc    = wd;
    end else if (op == 3'd3) begin
      if (!old_exl) begin
        m_epc = p;
        m_status[1] = 1'b1;
      end
      m_cause[6:2] = 5'd8;
      m_rv  = 1;
      m_rpc = EXC;
    end else if (op == 3'd4) begin
      m_status[1] = 1'b0;
      m_rv  = 1;
      m_rpc = old_epc;
    end
  endtask

  task automatic step(input logic [2:0] op, input logic [4:0] c,
                      input logic [2:0] s, input logic [31:0] wd,
                      input logic [31:0] p, input logic r);
    cp0Op = op; cs = c; sel = s; wdata = wd; pc = p; rst = r;
    #1;
    chk("rdata", rdata, m_read(op, c, s));
    @(posedge clk);
    model_edge(op, c, s, wd, p, r);
    #1;
    chk("epc", epc, m_epc);
    chk("status", status, m_status);
    chk("cause", cause, m_cause);
    chk("rv", {31'd0, redirect_valid}, {31'd0, m_rv});
    chk("rpc", redirect_pc, m_rpc);
  endtask

  task automatic idle();
    step(3'd0, 5'd0, 3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [4:0]  c;
    logic [2:0]  s;
    logic [4:0]  pick;
    rst = 1'b1; cp0Op = 0; cs = 0; sel = 0; wdata = 0; pc = 0;

    // reset together with a SYSCALL
    step(3'd3, 5'd0, 3'd0, 32'd0, 32'h0040_0040, 1'b1);
    chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_status", status, SRST);

    repeat (5) begin
      idle();
      chk("idle_rv", {31'd0, redirect_valid}, 32'd0);
    end
    cp0Op = 3'd1; cs = 5'd9; sel = 3'd0; rst = 1'b0;
    #1 chk("count5", rdata, 32'd5);
    step(3'd1, 5'd9, 3'd0, 32'd0, 32'd0, 1'b0);

    // MTC0 EPC then ERET
    step(3'd2, 5'd14, 3'd0, 32'h0040_0100, 32'd0, 1'b0);
    step(3'd4, 5'd0, 3'd0, 32'd0, 32'd0, 1'b0);
    chk("eret_rv", {31'd0, redirect_valid}, 32'd1);
    chk("eret_rpc", redirect_pc, 32'h0040_0100);
    chk("eret_exl", {31'd0, status[1]}, 32'd0);
    idle();
    chk("pulse_end", {31'd0, redirect_valid}, 32'd0);
    chk("rpc_hold", redirect_pc, 32'h0040_0100);

    // SYSCALL, then nested SYSCALL
    step(3'd3, 5'd0, 3'd0, 32'd0, 32'h0040_0020, 1'b0);
    chk("sys_epc", epc, 32'h0040_0020);
    chk("sys_code", {27'd0, cause[6:2]}, 32'd8);
    chk("sys_exl", {31'd0, status[1]}, 32'd1);
    chk("sys_rpc", redirect_pc, EXC);
    step(3'd3, 5'd0, 3'd0, 32'd0, 32'h0040_0080, 1'b0);
    chk("nest_epc", epc, 32'h0040_0020);
    chk("nest_rv", {31'd0, redirect_valid}, 32'd1);

    // back-to-back ERETs
    step(3'd4, 5'd0, 3'd0, 32'd0, 32'd0, 1'b0);
    chk("eret1_rv", {31'd0, redirect_valid}, 32'd1);
    step(3'd4, 5'd0, 3'd0, 32'd0, 32'd0, 1'b0);
    chk("eret2_rv", {31'd0, redirect_valid}, 32'd1);
    chk("eret2_rpc", redirect_pc, 32'h0040_0020);

    // Count wrap
    step(3'd2, 5'd9, 3'd0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    idle();
    cp0Op = 3'd1; cs = 5'd9; sel = 3'd0; rst = 1'b0;
    #1 chk("count_wrap", rdata, 32'd0);
    step(3'd1, 5'd9, 3'd0, 32'd0, 32'd0, 1'b0);

    // unimplemented register and nonzero bank
    step(3'd2, 5'd13, 3'd1, 32'hDEAD_BEEF, 32'd0, 1'b0);
    step(3'd1, 5'd13, 3'd1, 32'd0, 32'd0, 1'b0);
    step(3'd2, 5'd3, 3'd0, 32'h1234_5678, 32'd0, 1'b0);
    step(3'd1, 5'd3, 3'd0, 32'd0, 32'd0, 1'b0);

    // pending redirect killed by reset
    step(3'd3, 5'd0, 3'd0, 32'd0, 32'h0040_0200, 1'b0);
    step(3'd0, 5'd0, 3'd0, 32'd0, 32'd0, 1'b1);
    chk("rst_kill_rv", {31'd0, redirect_valid}, 32'd0);

    repeat (400) begin
      pick = 5'($urandom_range(0, 15));
      op = (pick < 4) ? 3'd1 : (pick < 9) ? 3'd2 :
           (pick < 11) ? 3'd3 : (pick < 13) ? 3'd4 :
           3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: c = 5'd9;
        1: c = 5'd12;
        2: c = 5'd13;
        3: c = 5'd14;
        default: c = 5'($urandom);
      endcase
      s = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
      step(op, c, s, $urandom, $urandom,
           $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_regs.md
CP0_REGS -- requirements
Module: cp0_regs

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h0000_0004, meaning the SYSCALL handler entry address.
REQ-002 Parameter STATUS_RESET, default 32'h0000_0000, meaning the Status reset value.
REQ-003 Port clk  input  1  is the sole clock, and all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  is a synchronous, active-high reset.
REQ-005 Port cp0Op  input  3  is the committing CP0 operation: 000 none, 001 MFC0, 010 MTCO, 011 SYSCALL, 100 ERET, others none.
REQ-006 Port cs  input  5  selects the CP0 register number.
REQ-007 Port sel  input  3  selects the CP0 register bank.
REQ-008 Port wdata  input  32  is the MTCO write data.
REQ-009 Port pc  input  32  is the address of the committing instruction.
REQ-010 Port rdata  output  32  is the MFC0 read data.
REQ-011 Port epc  output  32  is the current EPC, consumed by the ERET forwarding path.
REQ-012 Port status  output  32  is the current Status.
REQ-013 Port cause  output  32  is the current Cause.
REQ-014 Port redirect_valid  output  1  pulses for one cycle to request a PC redirect.
REQ-015 Port redirect_pc  output  32  is the redirect target, valid while redirect_valid is high.

Function
REQ-016 Implemented registers, all with sel=0: Count (cs=9), Status (cs=12), Cause (cs=13) and EPC (cs=14); any other cs/sel pair SHALL read as zero and ignore writes.
REQ-017 MFC0: rdata SHALL be combinational from cs/sel and SHALL show the pre-edge register value; rdata SHALL be 0 when cp0Op is not MFC0.
REQ-018 MTCO SHALL write wdata into the addressed register at the edge.
REQ-019 Count SHALL increment by 1 every cycle, wrapping from 32'hFFFF_FFFF to 0.
REQ-020 An MTCO to Count SHALL load wdata, and this load SHALL override the increment for that cycle.
REQ-021 SYSCALL with Status.EXL (bit 1) = 0 SHALL set EPC to pc, Cause[6:2] to 5'd8, and Status.EXL to 1.
REQ-022 SYSCALL with Status.EXL = 1 SHALL leave EPC unchanged, while still setting Cause[6:2] to 5'd8.
REQ-023 ERET SHALL clear Status.EXL; EPC and Cause SHALL be unchanged.
REQ-024 redirect_valid SHALL assert in the cycle after a SYSCALL or ERET commit, for exactly one cycle.
REQ-025 redirect_pc SHALL be registered: EXC_VECTOR after a SYSCALL, and after an ERET the EPC value sampled at the ERET edge.
REQ-026 When there is no redirect, redirect_pc SHALL hold its last value.
REQ-027 Back-to-back ERET cycles SHALL each produce a one-cycle redirect_valid pulse, giving consecutive pulses.
REQ-028 An MTCO to EPC in cycle N followed by ERET in cycle N+1 SHALL redirect to the newly written EPC.
REQ-029 epc, status and cause SHALL be direct register outputs with no combinational path from the inputs.

Reset
REQ-030 While rst is high at an edge, the block SHALL set Count, Cause, EPC and redirect_pc to 0, Status to STATUS_RESET, and redirect_valid to 0.
REQ-031 Reset SHALL take priority over every cp0Op, and any operation presented in a reset cycle SHALL be discarded.
REQ-032 A redirect pending from the cycle before reset SHALL NOT appear after reset.

Structure
REQ-033 The cp0Op encodings, the register numbers 9/12/13/14, the EXL bit index and ExcCode 8 SHALL live in a shared CP0 definitions include, also used by the CP0 forwarding unit.
REQ-034 The block SHALL be a single module with no sub-modules.

Verification
REQ-035 Reset, then idle for 5 cycles -> Count reads 5 by MFC0 and redirect_valid stays 0.
REQ-036 MTCO cs=14 with wdata 32'h0040_0100, then ERET on the next cycle -> redirect_valid pulses with redirect_pc 32'h0040_0100, and Status.EXL ends at 0.
REQ-037 SYSCALL with pc 32'h0040_0020 -> EPC is 32'h0040_0020, Cause[6:2] is 8, EXL is 1, and the redirect goes to EXC_VECTOR.
REQ-038 A second SYSCALL with pc 32'h0040_0080 while EXL=1 -> EPC stays 32'h0040_0020 and the redirect still occurs.
REQ-039 MTCO Count with 32'hFFFF_FFFF, then idle for 1 cycle -> Count reads 0.
REQ-040 rst asserted in the same cycle as a SYSCALL -> no redirect, EPC is 0, and Status equals STATUS_RESET.
